// File: rtl/div_16bit_recon_if.sv
// Operand/result bundle for the shift-add dividend reconstructor.
// The master side issues requests and the slave side (the reconstructor) returns results.
interface div_16bit_recon_if #(
  parameter int Q_WIDTH = 16,
  parameter int B_WIDTH = 8
);
  logic                         start;
  logic [Q_WIDTH-1:0]           quotient;
  logic [B_WIDTH-1:0]           divisor;
  logic [Q_WIDTH-1:0]           odd;
  logic                         busy;
  logic                         done;
  logic [Q_WIDTH-1:0]           result;
  logic [Q_WIDTH+B_WIDTH:0]     result_full;
  logic                         ovf;
  logic                         rem_err;

  modport master (
    output start, quotient, divisor, odd,
    input  busy, done, result, result_full, ovf, rem_err
  );

  modport slave (
    input  start, quotient, divisor, odd,
    output busy, done, result, result_full, ovf, rem_err
  );
endinterface

// File: rtl/div_16bit_recon.sv
// Sequential shift-add reconstructor: computes D = Q*B + R over B_WIDTH iterations,
// flagging dividends wider than Q_WIDTH bits and remainders not below the divisor.
module div_16bit_recon #(
  parameter int Q_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  div_16bit_recon_if.slave bus
);
  localparam int ACC_W = Q_WIDTH + B_WIDTH + 1;
  localparam int CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   q_sh_q, q_sh_d;
  logic [B_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rem_nxt_q, rem_nxt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [Q_WIDTH-1:0] result_q, result_d;
  logic [ACC_W-1:0]   result_full_q, result_full_d;
  logic               ovf_q, ovf_d;
  logic               rem_err_q, rem_err_d;
  logic [ACC_W-1:0]   acc_sum;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    q_sh_d        = q_sh_q;
    b_sh_d        = b_sh_q;
    cnt_d         = cnt_q;
    rem_nxt_d     = rem_nxt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    result_full_d = result_full_q;
    ovf_d         = ovf_q;
    rem_err_d     = rem_err_q;
    acc_sum       = acc_q + (b_sh_q[0] ? q_sh_q : '0);

    case (state_q)
      // The edge that closes the DONE cycle accepts a new request, giving
      // one operation every B_WIDTH+1 cycles.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          acc_d     = ACC_W'(bus.odd);
          q_sh_d    = ACC_W'(bus.quotient);
          b_sh_d    = bus.divisor;
          cnt_d     = '0;
          rem_nxt_d = (ACC_W'(bus.odd) >= ACC_W'(bus.divisor));
          busy_d    = 1'b1;
          state_d   = S_CALC;
        end else begin
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d  = acc_sum;
        q_sh_d = q_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_full_d = acc_sum;
          result_d      = acc_sum[Q_WIDTH-1:0];
          ovf_d         = |acc_sum[ACC_W-1:Q_WIDTH];
          rem_err_d     = rem_nxt_q;
          done_d        = 1'b1;
          state_d       = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      q_sh_q        <= '0;
      b_sh_q        <= '0;
      cnt_q         <= '0;
      rem_nxt_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      result_full_q <= '0;
      ovf_q         <= 1'b0;
      rem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      q_sh_q        <= q_sh_d;
      b_sh_q        <= b_sh_d;
      cnt_q         <= cnt_d;
      rem_nxt_q     <= rem_nxt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      result_full_q <= result_full_d;
      ovf_q         <= ovf_d;
      rem_err_q     <= rem_err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_full = result_full_q;
  assign bus.ovf         = ovf_q;
  assign bus.rem_err     = rem_err_q;
endmodule

// File: tb/tb_div_16bit_recon.sv
// Testbench for div_16bit_recon: directed and randomized operations compared
// against an arithmetic model of D = Q*B + R.
module tb_div_16bit_recon;
  localparam int QW = 16;
  localparam int BW = 8;
  localparam int FW = QW + BW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_16bit_recon_if #(.Q_WIDTH(QW), .B_WIDTH(BW)) bus ();

  div_16bit_recon #(.Q_WIDTH(QW), .B_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic.
  function automatic logic [FW-1:0] model_full(input logic [QW-1:0] q,
                                               input logic [BW-1:0] b,
                                               input logic [QW-1:0] r);
    longint unsigned v;
    v = longint'(q) * longint'(b) + longint'(r);
    return FW'(v);
  endfunction

  function automatic logic model_ovf(input logic [FW-1:0] f);
    return (f > FW'(65535));
  endfunction

  function automatic logic model_rem(input logic [BW-1:0] b, input logic [QW-1:0] r);
    return (int'(r) >= int'(b));
  endfunction

  // Issue one request at a negedge and wait (bounded) for done.
  // lat = negedges from the start edge until done is seen, -1 on timeout.
  task automatic run_op(input logic [QW-1:0] q, input logic [BW-1:0] b,
                        input logic [QW-1:0] r, output int lat, output int busy_cyc);
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.quotient = q; bus.divisor = b; bus.odd = r;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; busy_cyc = 0; seen = 0;
    for (int n = 1; n <= 30 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin lat = n; seen = 1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.quotient = '0; bus.divisor = '0; bus.odd = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result_full !== '0 || bus.result !== '0) begin errors++;
      $display("FAIL reset_result got %h/%h want 0", bus.result_full, bus.result); end
    checks++; if (bus.ovf !== 1'b0 || bus.rem_err !== 1'b0) begin errors++;
      $display("FAIL reset_flags got %b%b want 00", bus.ovf, bus.rem_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(16'd100, 8'd7, 16'd3, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
    checks++; if (bus.result !== 16'h02BF) begin errors++; $display("FAIL basic_result got %h want 02bf", bus.result); end
    checks++; if (bus.result_full !== FW'(703)) begin errors++; $display("FAIL basic_full got %0d want 703", bus.result_full); end
    checks++; if (bus.ovf !== 1'b0 || bus.rem_err !== 1'b0) begin errors++;
      $display("FAIL basic_flags got %b%b want 00", bus.ovf, bus.rem_err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL basic_after_done got done=%b busy=%b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_directed();
    logic [QW-1:0] qs [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'd9};
    logic [BW-1:0] bs [4] = '{8'h10,   8'hFF,    8'hFF,    8'h00};
    logic [QW-1:0] rs [4] = '{16'h0005, 16'h00FE, 16'h00FF, 16'd5};
    logic [FW-1:0] exp_f;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(qs[i], bs[i], rs[i], lat, bc);
      exp_f = model_full(qs[i], bs[i], rs[i]);
      checks++; if (bus.result_full !== exp_f || bus.result !== exp_f[QW-1:0]) begin errors++;
        $display("FAIL directed%0d_value got %h/%h want %h/%h", i, bus.result_full, bus.result, exp_f, exp_f[QW-1:0]); end
      checks++; if (bus.ovf !== model_ovf(exp_f) || bus.rem_err !== model_rem(bs[i], rs[i])) begin errors++;
        $display("FAIL directed%0d_flags got ovf=%b rem=%b want ovf=%b rem=%b", i, bus.ovf, bus.rem_err,
                 model_ovf(exp_f), model_rem(bs[i], rs[i])); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL directed%0d_latency got %0d want 9", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [QW-1:0] q, r;
    logic [BW-1:0] b;
    logic [FW-1:0] exp_f;
    int lat, bc;
    for (int i = 0; i < 25; i++) begin
      q = QW'($urandom_range(0, 65535));
      b = BW'($urandom_range(0, 255));
      if (i % 2 == 0 && b != 0) r = QW'($urandom % b);
      else                      r = QW'($urandom_range(0, 65535));
      run_op(q, b, r, lat, bc);
      exp_f = model_full(q, b, r);
      checks++; if (lat !== 9 || bus.result_full !== exp_f || bus.result !== exp_f[QW-1:0] ||
                    bus.ovf !== model_ovf(exp_f) || bus.rem_err !== model_rem(b, r)) begin errors++;
        $display("FAIL random%0d q=%h b=%h r=%h got lat=%0d full=%h res=%h ovf=%b rem=%b want lat=9 full=%h ovf=%b rem=%b",
                 i, q, b, r, lat, bus.result_full, bus.result, bus.ovf, bus.rem_err,
                 exp_f, model_ovf(exp_f), model_rem(b, r)); end
    end
  endtask

  task automatic test_operand_capture();
    int dones = 0;
    int first = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.quotient = 16'd3; bus.divisor = 8'd5; bus.odd = 16'd1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.done) begin dones++; if (first < 0) first = n; end
      if (n >= 2 && n <= 5) begin
        bus.start = 1'b1; bus.quotient = 16'hFFFF; bus.divisor = 8'hAB; bus.odd = 16'h7777;
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++; if (dones !== 1 || first !== 9) begin errors++;
      $display("FAIL capture_done_pulses got %0d first=%0d want 1 first=9", dones, first); end
    checks++; if (bus.result !== 16'h0010 || bus.result_full !== FW'(16)) begin errors++;
      $display("FAIL capture_result got %h want 0010", bus.result); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp_a, exp_b;
    int lat, bc;
    bit seen = 0;
    exp_a = model_full(16'd777, 8'd200, 16'd150);
    exp_b = model_full(16'd4321, 8'd3, 16'd2);
    run_op(16'd777, 8'd200, 16'd150, lat, bc);
    // done is visible now; a request presented here is taken at the edge ending DONE
    bus.start = 1'b1; bus.quotient = 16'd4321; bus.divisor = 8'd3; bus.odd = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++;
      $display("FAIL b2b_busy got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    checks++; if (bus.result_full !== exp_a) begin errors++;
      $display("FAIL b2b_hold got %h want %h", bus.result_full, exp_a); end
    lat = -1;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.done) begin lat = n; seen = 1; end
    end
    checks++; if (lat !== 9 || bus.result_full !== exp_b) begin errors++;
      $display("FAIL b2b_second got lat=%0d full=%h want lat=9 full=%h", lat, bus.result_full, exp_b); end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int lat, bc;
    @(negedge clk);
    bus.start = 1'b1; bus.quotient = 16'd100; bus.divisor = 8'd7; bus.odd = 16'd3;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.result !== '0 || bus.result_full !== '0 || bus.ovf !== 1'b0 || bus.rem_err !== 1'b0) begin errors++;
      $display("FAIL midrst_outputs got %h/%h ovf=%b rem=%b want zeros", bus.result, bus.result_full, bus.ovf, bus.rem_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    run_op(16'd100, 8'd7, 16'd3, lat, bc);
    checks++; if (lat !== 9 || bus.result_full !== FW'(703)) begin errors++;
      $display("FAIL midrst_recover got lat=%0d full=%0d want 9 703", lat, bus.result_full); end
  endtask

  initial begin
    bus.start = 1'b0; bus.quotient = '0; bus.divisor = '0; bus.odd = '0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_operand_capture();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
